// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: operands are folded into a carry-save (S, C) pair
// one per cycle, then C is rippled into S iteratively before the result is offered.
module csa_accum_ctrl #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] maj;
  logic [ACC_W-1:0] sc_and;
  logic             accept;

  always_comb begin
    x = '0;
    x[WIDTH-1:0] = in_data;
  end

  // Per-bit 3:2 compressor carry (majority of S, C, x) and the 2:2 resolve carry.
  genvar gi;
  generate
    for (gi = 0; gi < ACC_W; gi++) begin : g_csa
      assign maj[gi]    = (s_q[gi] & c_q[gi]) | (s_q[gi] & x[gi]) | (c_q[gi] & x[gi]);
      assign sc_and[gi] = s_q[gi] & c_q[gi];
    end
  endgenerate

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          s_d     = x;
          c_d     = '0;
          count_d = 8'd1;
          ovf_d   = 1'b0;
          state_d = in_last ? RESOLVE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          s_d     = s_q ^ c_q ^ x;
          c_d     = maj << 1;
          count_d = (count_q == 8'd255) ? count_q : count_q + 8'd1;
          // A carry out of the top bit means the true total has passed 2^ACC_W.
          if (maj[ACC_W-1]) ovf_d = 1'b1;
          if (in_last) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        if (c_q == '0) begin
          state_d = DONE;
        end else begin
          s_d = s_q ^ c_q;
          c_d = sc_and << 1;
          if (sc_and[ACC_W-1]) ovf_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE) || (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = s_q;
  assign out_count = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Scoreboard bench for csa_accum_ctrl: the stimulus side predicts each group's
// total with plain integer arithmetic; a monitor checks every result handshake.
module tb_csa_accum_ctrl;
  localparam int W = 4;
  localparam int A = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [A-1:0] out_sum;
  logic [7:0]   out_count;
  logic         overflow;

  csa_accum_ctrl #(.WIDTH(W), .ACC_W(A)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_edge = -1;
  int first_valid_edge = -1;
  int pushed = 0;
  int popped = 0;
  int ready_mode = 2;  // 0 random, 1 held low, 2 held high
  int exp_sum[$];
  int exp_cnt[$];
  int exp_ovf[$];
  int grp[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge.
  logic         prev_valid = 1'b0, prev_stall = 1'b0, prev_hs = 1'b0;
  logic [A-1:0] prev_sum;
  logic [7:0]   prev_cnt;
  logic         prev_ovf;
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      prev_valid = 1'b0; prev_stall = 1'b0; prev_hs = 1'b0;
    end else begin
      if (cyc == last_edge) check("in_ready_after_last", int'(in_ready), 0);
      if (prev_hs) begin
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_in_ready", int'(in_ready), 1);
      end
      if (out_valid) begin
        check("in_ready_in_done", int'(in_ready), 0);
        if (!prev_valid) first_valid_edge = cyc;
        if (prev_stall) begin
          check("stall_sum", int'(out_sum), int'(prev_sum));
          check("stall_count", int'(out_count), int'(prev_cnt));
          check("stall_ovf", int'(overflow), int'(prev_ovf));
        end
      end
      prev_hs = out_valid && out_ready;
      if (prev_hs) begin
        if (exp_sum.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          int es, ec, eo;
          es = exp_sum.pop_front(); ec = exp_cnt.pop_front(); eo = exp_ovf.pop_front();
          popped++;
          $display("txn %0d: sum=%0d count=%0d ovf=%0d (exp %0d %0d %0d)",
                   popped, out_sum, out_count, overflow, es, ec, eo);
          check("out_sum", int'(out_sum), es);
          check("out_count", int'(out_count), ec);
          check("overflow", int'(overflow), eo);
        end
      end
      prev_valid = out_valid;
      prev_stall = out_valid && !out_ready;
      prev_sum = out_sum; prev_cnt = out_count; prev_ovf = overflow;
    end
  end

  // Offer one operand; while in_ready is low, garbage is presented with in_valid high.
  task automatic send_op(input int d, input bit last, input int vprob);
    bit done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (!in_ready) begin
        in_valid = 1'b1;
        in_data  = W'($urandom_range(0, 15));
        in_last  = 1'($urandom_range(0, 1));
      end else begin
        in_valid = ($urandom_range(0, 99) < vprob);
        in_data  = W'(d);
        in_last  = last;
        if (in_valid) begin
          done = 1'b1;
          if (last) last_edge = cyc + 1;
        end
      end
    end
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic run_group(input int vprob);
    int sum = 0;
    int n = grp.size();
    for (int i = 0; i < n; i++) begin
      send_op(grp[i], (i == n - 1), vprob);
      sum += grp[i];
    end
    exp_sum.push_back(sum % 256);
    exp_cnt.push_back(n > 255 ? 255 : n);
    exp_ovf.push_back(sum >= 256 ? 1 : 0);
    pushed++;
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int t = 0; t < 800 && !done; t++) begin
      @(negedge clk);
      in_valid = !in_ready;
      in_data  = W'($urandom_range(0, 15));
      in_last  = 1'($urandom_range(0, 1));
      #2;
      done = (popped == pushed);
    end
    if (!done) check("result_timeout", popped, pushed);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic fill(input int n, input int v);
    grp.delete();
    for (int i = 0; i < n; i++) grp.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_count", int'(out_count), 0);
    check("reset_ovf", int'(overflow), 0);

    grp = '{15, 15, 15};
    run_group(100); wait_done();
    check("latency_15x3", first_valid_edge - last_edge, 3);

    grp = '{9};
    run_group(100); wait_done();
    check("latency_single", first_valid_edge - last_edge, 1);

    fill(17, 15); run_group(100); wait_done();
    fill(18, 15); run_group(100); wait_done();

    grp = '{1, 2, 3, 4, 5};
    run_group(50); wait_done();

    // Hold the consumer off on an overflowing group, then release.
    ready_mode = 1;
    fill(18, 15); run_group(100);
    for (int t = 0; t < 200 && !out_valid; t++) begin
      @(negedge clk); in_valid = 1'b0; #1;
    end
    check("stall_reached_done", int'(out_valid), 1);
    repeat (10) @(negedge clk);
    ready_mode = 2;
    wait_done();
    grp = '{6};
    run_group(100); wait_done();

    // Abort a group mid-way with reset.
    send_op(5, 1'b0, 100);
    send_op(6, 1'b0, 100);
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    grp = '{7, 8};
    run_group(100); wait_done();

    // Randomised groups with random backpressure, then one count-saturating group.
    ready_mode = 0;
    for (int g = 0; g < 20; g++) begin
      int n = $urandom_range(1, 25);
      grp.delete();
      for (int i = 0; i < n; i++) grp.push_back($urandom_range(0, 15));
      run_group($urandom_range(30, 100));
      if ($urandom_range(0, 1) == 1) wait_done();
    end
    wait_done();
    grp.delete();
    for (int i = 0; i < 260; i++) grp.push_back($urandom_range(0, 15));
    run_group(80); wait_done();

    check("queue_drained", exp_sum.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
